// File: rtl/fifo_wm.sv
// First-word-fall-through FIFO with concurrent push/pop, fill level, programmable
// almost-empty/almost-full watermarks, sticky w1c overflow/underflow and a synchronous flush.
module fifo_wm #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ov_clear,
    input  logic             uf_clear,
    input  logic [LW-1:0]    ae_thresh,
    input  logic [LW-1:0]    af_thresh,
    output logic [WIDTH-1:0] data_out,
    output logic [LW-1:0]    level,
    output logic             fe,
    output logic             ff,
    output logic             ae,
    output logic             af,
    output logic             ov,
    output logic             uf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [LW-1:0] level_q, level_d;
    logic          ov_q, ov_d;
    logic          uf_q, uf_d;

    logic rd, wr;
    logic is_empty, is_full;
    logic push, pop;
    logic set_ov, set_uf;
    logic mem_we;

    assign rd       = chipselect & read;
    assign wr       = chipselect & write;
    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == FullLevel);

    // A pop on a full FIFO frees the slot on the same edge, so the push still lands.
    // A pop on an empty FIFO is never bypassed from the incoming write.
    assign push   = wr & (~is_full | rd);
    assign pop    = rd & ~is_empty;
    assign set_ov = wr & is_full & ~rd;
    assign set_uf = rd & is_empty;
    assign mem_we = push & ~flush & ~reset;

    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        level_d = level_q;
        ov_d    = ov_q & ~ov_clear;
        uf_d    = uf_q & ~uf_clear;
        if (flush) begin
            rp_d    = '0;
            wp_d    = '0;
            level_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + 1'b1;
            end
            if (pop) begin
                rp_d = rp_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            // Set beats a simultaneous clear.
            if (set_ov) begin
                ov_d = 1'b1;
            end
            if (set_uf) begin
                uf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp_q    <= '0;
            wp_q    <= '0;
            level_q <= '0;
            ov_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            level_q <= level_d;
            ov_q    <= ov_d;
            uf_q    <= uf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wp_q] <= data_in;
        end
    end

    assign level    = level_q;
    assign fe       = is_empty;
    assign ff       = is_full;
    assign ae       = (level_q <= ae_thresh);
    assign af       = (level_q >= af_thresh);
    assign ov       = ov_q;
    assign uf       = uf_q;
    assign data_out = is_empty ? '0 : mem[rp_q];

endmodule

// File: tb/tb_fifo_wm.sv
// Directed bench for fifo_wm (DEPTH=16, WIDTH=32): a vector table for short single-cycle
// cases plus hand-written sequences for fill/drain, wrap, watermarks and reset mid-burst.
module tb_fifo_wm;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LW    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             chipselect = 1'b0;
    logic             read = 1'b0;
    logic             write = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             ov_clear = 1'b0;
    logic             uf_clear = 1'b0;
    logic [LW-1:0]    ae_thresh = 5'd2;
    logic [LW-1:0]    af_thresh = 5'd14;
    logic [WIDTH-1:0] data_out;
    logic [LW-1:0]    level;
    logic             fe, ff, ae, af, ov, uf;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wm #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .flush      (flush),
        .data_in    (data_in),
        .ov_clear   (ov_clear),
        .uf_clear   (uf_clear),
        .ae_thresh  (ae_thresh),
        .af_thresh  (af_thresh),
        .data_out   (data_out),
        .level      (level),
        .fe         (fe),
        .ff         (ff),
        .ae         (ae),
        .af         (af),
        .ov         (ov),
        .uf         (uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        rd;
        logic        wr;
        logic        fl;
        logic        ovc;
        logic        ufc;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic [4:0]  exp_level;
        logic        exp_ov;
        logic        exp_uf;
    } vec_t;

    vec_t vecs [20];

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic cs, input logic rd, input logic wr,
                       input logic fl, input logic [31:0] din, input logic ovc,
                       input logic ufc);
        reset      = rst;
        chipselect = cs;
        read       = rd;
        write      = wr;
        flush      = fl;
        data_in    = din;
        ov_clear   = ovc;
        uf_clear   = ufc;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        flush    = 1'b0;
        ov_clear = 1'b0;
        uf_clear = 1'b0;
    endtask

    // Status flags are derived from the expected level and the live thresholds.
    task automatic check(input string name, input logic [31:0] e_data, input logic [4:0] e_lvl,
                         input logic e_ov, input logic e_uf);
        logic [44:0] got, exp;
        got = {data_out, level, fe, ff, ae, af, ov, uf};
        exp = {e_data, e_lvl, (e_lvl == 5'd0), (e_lvl == 5'd16), (e_lvl <= ae_thresh),
               (e_lvl >= af_thresh), e_ov, e_uf};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got data=%h lvl=%0d fe%b ff%b ae%b af%b ov%b uf%b, want %h",
                     name, data_out, level, fe, ff, ae, af, ov, uf, exp);
        end
    endtask

    task automatic check_wm(input string name, input logic e_ae, input logic e_af);
        n_tests++;
        if (ae !== e_ae || af !== e_af) begin
            n_fail++;
            $display("FAIL %s: got ae=%b af=%b, want ae=%b af=%b", name, ae, af, e_ae, e_af);
        end
    endtask

    initial begin
        //            rst   cs    rd    wr    fl    ovc   ufc   din     data    lvl  ov    uf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 32'h11, 5'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 32'h11, 5'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 32'h22, 5'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h33, 5'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  5'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  5'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  5'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  5'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h99, 32'h0,  5'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h55, 5'd1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h66, 32'h55, 5'd2, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h55, 5'd3, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h88, 32'h55, 5'd4, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h99, 32'h55, 5'd5, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAB, 32'h0,  5'd0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  5'd0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  5'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5A, 32'h5A, 5'd1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7E, 32'h0,  5'd0, 1'b0, 1'b0};

        #2;
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].fl, vecs[i].din,
                vecs[i].ovc, vecs[i].ufc);
            check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_level,
                  vecs[i].exp_ov, vecs[i].exp_uf);
        end

        // Fill, overflow, set-beats-clear on ov, then drain in order.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
            check($sformatf("fill%0d", i), 32'h1, 5'(i), 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b0);
        check("overflow", 32'h1, 5'd16, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("ov_clear", 32'h1, 5'd16, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD, 1'b1, 1'b0);
        check("ov_set_wins", 32'h1, 5'd16, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check($sformatf("drain%0d", k), (k < 16) ? 32'(k + 1) : 32'h0, 5'(16 - k),
                  1'b1, 1'b0);
        end

        // Full with rd&wr every cycle: pointers wrap, level pinned at 16, no overflow.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        check("refill", 32'h100, 5'd16, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hAA, 1'b0, 1'b0);
            check($sformatf("rdwr_full%0d", k), (k < 16) ? 32'h100 + 32'(k) : 32'hAA, 5'd16,
                  1'b0, 1'b0);
        end
        for (int j = 1; j <= 16; j++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check($sformatf("wrap_drain%0d", j), (j < 16) ? 32'hAA : 32'h0, 5'(16 - j),
                  1'b0, 1'b0);
        end

        // Watermarks across every level, then thresholds above DEPTH.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ae_thresh = 5'd2;
        af_thresh = 5'd14;
        #1;
        check_wm("wm_lvl0", 1'b1, 1'b0);
        for (int l = 1; l <= 16; l++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'(l), 1'b0, 1'b0);
            check_wm($sformatf("wm_lvl%0d", l), l <= 2, l >= 14);
        end
        af_thresh = 5'd17;
        ae_thresh = 5'd17;
        #1;
        check_wm("wm_above_depth", 1'b1, 1'b0);
        ae_thresh = 5'd2;
        af_thresh = 5'd14;

        // Reset mid-burst with both sticky flags set and rd&wr held high.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hBEEF, 1'b0, 1'b0);
        check("pre_reset_ov", 32'h1, 5'd16, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("pre_reset_uf", 32'h0, 5'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC2, 1'b0, 1'b0);
        check("burst", 32'hC2, 5'd1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC3, 1'b0, 1'b0);
        check("reset_mid_burst", 32'h0, 5'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
